token_dispatch: RTL and testbench

Round-robin dispatcher between the token FIFO and the NUM_PARSER parallel parsers of the Snappy decompressor. It reads tokens from the token FIFO, which has a 1-cycle read latency, into a 2-entry buffer. It hands tokens to parsers in strict cyclic order, so the downstream RAM/output logic can restore order. It also reports block boundaries and end-of-job drain to the top-level control FSM.

---
 rtl/token_dispatch_if.sv | 25 ++
 rtl/token_dispatch.sv | 83 ++++++++
 tb/tb_token_dispatch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/token_dispatch_if.sv
// token_dispatch_if: token FIFO read port, parser offer bus and job status of the dispatcher
interface token_dispatch_if #(
  parameter int NUM_PARSER = 6,
  parameter int TOKEN_W = 136
);
  logic start;
  logic page_input_finish;
  logic tf_empty;
  logic [TOKEN_W-1:0] tf_dout;
  logic tf_rd;
  logic [NUM_PARSER-1:0] ps_ready;
  logic [NUM_PARSER-1:0] ps_valid;
  logic [TOKEN_W-1:0] ps_data;
  logic block_done;
  logic disp_done;
  logic [31:0] tok_cnt;
  modport master (
    input start, page_input_finish, tf_empty, tf_dout, ps_ready,
    output tf_rd, ps_valid, ps_data, block_done, disp_done, tok_cnt
  );
  modport slave (
    output start, page_input_finish, tf_empty, tf_dout, ps_ready,
    input tf_rd, ps_valid, ps_data, block_done, disp_done, tok_cnt
  );
endinterface

// File: rtl/token_dispatch.sv
// token_dispatch: round-robin token dispatcher from a 1-cycle-latency FIFO into a 2-entry buffer,
// offering tokens to parsers in strict cyclic order and reporting block ends and job drain.
module token_dispatch #(
  parameter int NUM_PARSER = 6,
  parameter int TOKEN_W = 136
) (
  input logic clk,
  input logic rst_n,
  token_dispatch_if.master bus
);
  localparam int PW = $clog2(NUM_PARSER);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic [TOKEN_W-1:0] r_buf [2];
  logic [1:0] r_occ;
  logic r_pend;
  logic [PW-1:0] r_ptr;
  logic r_block_done;
  logic r_disp_done;
  logic [31:0] r_tok_cnt;

  logic w_run;
  logic w_xfer;
  logic w_head_last;
  logic w_wr;
  logic [1:0] w_fill;
  logic [PW-1:0] w_ptr_nxt;
  logic [NUM_PARSER-1:0] w_valid;

  always_comb begin
    w_run = r_state == S_RUN;
    w_valid = (w_run && r_occ != 2'd0) ? {{(NUM_PARSER-1){1'b0}}, 1'b1} << r_ptr : '0;
    w_xfer = |(w_valid & bus.ps_ready);
    w_head_last = r_buf[0][TOKEN_W-1];
    w_fill = r_occ + {1'b0, r_pend} - {1'b0, w_xfer};
    // a capture lands behind whatever survives this cycle's pop
    w_wr = (r_occ - {1'b0, w_xfer}) != 2'd0;
    w_ptr_nxt = (w_head_last || r_ptr == PW'(NUM_PARSER-1)) ? '0 : r_ptr + 1'b1;
  end

  assign bus.tf_rd = w_run && !bus.tf_empty && w_fill < 2'd2;
  assign bus.ps_valid = w_valid;
  assign bus.ps_data = r_buf[0];
  assign bus.block_done = r_block_done;
  assign bus.disp_done = r_disp_done;
  assign bus.tok_cnt = r_tok_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_occ <= 2'd0;
      r_pend <= 1'b0;
      r_ptr <= '0;
      r_block_done <= 1'b0;
      r_disp_done <= 1'b0;
      r_tok_cnt <= '0;
    end else begin
      r_pend <= bus.tf_rd;
      r_occ <= w_fill;
      r_block_done <= w_xfer && w_head_last;
      if (w_xfer) begin
        r_buf[0] <= r_buf[1];
        r_tok_cnt <= r_tok_cnt + 32'd1;
        r_ptr <= w_ptr_nxt;
      end
      if (r_pend) r_buf[w_wr] <= bus.tf_dout;
      if (!w_run && bus.start) begin
        r_state <= S_RUN;
        r_ptr <= '0;
        r_tok_cnt <= '0;
        r_disp_done <= 1'b0;
      end else if (w_run && bus.page_input_finish && bus.tf_empty && r_occ == 2'd0 && !r_pend) begin
        r_state <= S_DONE;
        r_disp_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_token_dispatch.sv
// tb_token_dispatch: table-driven and directed checks of token_dispatch against a FIFO model
module tb_token_dispatch;
  localparam int NP = 6;
  localparam int TW = 136;

  typedef struct {
    logic [15:0] id;
    logic last;
    logic [5:0] oh;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  token_dispatch_if #(.NUM_PARSER(NP), .TOKEN_W(TW)) bus ();
  token_dispatch #(.NUM_PARSER(NP), .TOKEN_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [TW-1:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign bus.tf_empty = (rp == wp);
  always @(posedge clk) if (bus.tf_rd) begin
    bus.tf_dout <= mem[rp];
    rp <= rp + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] log_oh [0:63];
  logic [15:0] log_id [0:63];
  int log_cyc [0:63];
  int log_n = 0;
  int bd_n = 0;
  int rd_n = 0;
  always @(negedge clk) if (rst_n) begin
    if (|(bus.ps_valid & bus.ps_ready)) begin
      log_oh[log_n] <= bus.ps_valid;
      log_id[log_n] <= bus.ps_data[15:0];
      log_cyc[log_n] <= cyc;
      log_n <= log_n + 1;
    end
    if (bus.block_done) bd_n <= bd_n + 1;
    if (bus.tf_rd) rd_n <= rd_n + 1;
  end

  int n_chk = 0;
  int n_err = 0;
  vec_t tab [17];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [15:0] id, input logic last);
    mem[wp] = {last, {(TW-17){1'b0}}, id};
    wp++;
  endtask

  task automatic wait_xfer(input int n);
    for (int i = 0; i < 200 && log_n < n; i++) tick();
    chk("xfer_count", 64'(log_n), 64'(n));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int s;
    int rd0;
    for (int i = 0; i < 12; i++) tab[i] = '{id: 16'(i + 1), last: 1'b0, oh: 6'(1 << (i % 6))};
    tab[12] = '{id: 16'd101, last: 1'b0, oh: 6'b000001};
    tab[13] = '{id: 16'd102, last: 1'b0, oh: 6'b000010};
    tab[14] = '{id: 16'd103, last: 1'b0, oh: 6'b000100};
    tab[15] = '{id: 16'd104, last: 1'b1, oh: 6'b001000};
    tab[16] = '{id: 16'd105, last: 1'b0, oh: 6'b000001};
    bus.start = 1'b0;
    bus.page_input_finish = 1'b0;
    bus.ps_ready = '0;
    repeat (3) tick();
    chk("rst_tf_rd", 64'(bus.tf_rd), 0);
    chk("rst_ps_valid", 64'(bus.ps_valid), 0);
    chk("rst_ps_data", 64'(bus.ps_data[63:0]), 0);
    chk("rst_block_done", 64'(bus.block_done), 0);
    chk("rst_disp_done", 64'(bus.disp_done), 0);
    chk("rst_tok_cnt", 64'(bus.tok_cnt), 0);
    rst_n = 1'b1;
    tick();
    // basic dispatch, all parsers ready
    bus.ps_ready = '1;
    for (int i = 0; i < 12; i++) push(tab[i].id, tab[i].last);
    s = cyc;
    pulse_start();
    wait_xfer(12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("basic_oh%0d", i), 64'(log_oh[i]), 64'(tab[i].oh));
      chk($sformatf("basic_id%0d", i), 64'(log_id[i]), 64'(tab[i].id));
    end
    chk("first_latency", 64'(log_cyc[0] - s), 3);
    chk("throughput", 64'(log_cyc[11] - log_cyc[0]), 11);
    repeat (2) tick();
    chk("basic_tok_cnt", 64'(bus.tok_cnt), 12);
    bus.page_input_finish = 1'b1;
    repeat (3) tick();
    chk("basic_disp_done", 64'(bus.disp_done), 1);
    // block end restarts the rotation at parser 0
    bus.page_input_finish = 1'b0;
    for (int i = 12; i < 17; i++) push(tab[i].id, tab[i].last);
    pulse_start();
    chk("restart_disp_done", 64'(bus.disp_done), 0);
    chk("restart_tok_cnt", 64'(bus.tok_cnt), 0);
    wait_xfer(17);
    for (int i = 12; i < 17; i++) begin
      chk($sformatf("blk_oh%0d", i), 64'(log_oh[i]), 64'(tab[i].oh));
      chk($sformatf("blk_id%0d", i), 64'(log_id[i]), 64'(tab[i].id));
    end
    repeat (2) tick();
    chk("blk_done_pulses", 64'(bd_n), 1);
    chk("blk_tok_cnt", 64'(bus.tok_cnt), 5);
    // strict order: parser 2 not ready stalls everything
    push(16'd200, 1'b0);
    wait_xfer(18);
    chk("order_pre_oh", 64'(log_oh[17]), 64'(6'b000010));
    tick();
    bus.ps_ready = 6'b111011;
    push(16'd201, 1'b0);
    repeat (6) tick();
    chk("order_stall_valid", 64'(bus.ps_valid), 64'(6'b000100));
    chk("order_stall_noxfer", 64'(log_n), 18);
    bus.ps_ready = '1;
    wait_xfer(19);
    chk("order_rel_oh", 64'(log_oh[18]), 64'(6'b000100));
    chk("order_rel_id", 64'(log_id[18]), 201);
    push(16'd202, 1'b0);
    wait_xfer(20);
    chk("order_next_oh", 64'(log_oh[19]), 64'(6'b001000));
    // buffer full under stall
    tick();
    bus.ps_ready = '0;
    rd0 = rd_n;
    for (int i = 0; i < 4; i++) push(16'(300 + i), 1'b0);
    repeat (10) tick();
    chk("full_rd_pulses", 64'(rd_n - rd0), 2);
    chk("full_tf_rd", 64'(bus.tf_rd), 0);
    bus.ps_ready = '1;
    wait_xfer(24);
    for (int i = 0; i < 4; i++) chk($sformatf("full_id%0d", i), 64'(log_id[20 + i]), 64'(300 + i));
    chk("full_oh0", 64'(log_oh[20]), 64'(6'b010000));
    chk("full_oh2", 64'(log_oh[22]), 64'(6'b000001));
    // finish while a token is still buffered
    tick();
    bus.ps_ready = '0;
    push(16'd400, 1'b0);
    repeat (4) tick();
    bus.page_input_finish = 1'b1;
    repeat (4) tick();
    chk("fin_held_disp_done", 64'(bus.disp_done), 0);
    bus.ps_ready = '1;
    wait_xfer(25);
    repeat (3) tick();
    chk("fin_disp_done", 64'(bus.disp_done), 1);
    bus.page_input_finish = 1'b0;
    push(16'd401, 1'b0);
    pulse_start();
    chk("fin_restart_tok_cnt", 64'(bus.tok_cnt), 0);
    wait_xfer(26);
    chk("fin_restart_oh", 64'(log_oh[25]), 64'(6'b000001));
    // reset while the buffer is full and a read is being issued
    tick();
    bus.ps_ready = '0;
    for (int i = 0; i < 4; i++) push(16'(500 + i), 1'b0);
    repeat (6) tick();
    bus.ps_ready = '1;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_tf_rd", 64'(bus.tf_rd), 0);
    chk("mid_rst_ps_valid", 64'(bus.ps_valid), 0);
    chk("mid_rst_ps_data", 64'(bus.ps_data[63:0]), 0);
    chk("mid_rst_block_done", 64'(bus.block_done), 0);
    chk("mid_rst_disp_done", 64'(bus.disp_done), 0);
    chk("mid_rst_tok_cnt", 64'(bus.tok_cnt), 0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_xfer(27);
    chk("mid_rst_oh", 64'(log_oh[26]), 64'(6'b000001));
    chk("mid_rst_id", 64'(log_id[26]), 503);
    repeat (2) tick();
    chk("mid_rst_tok_cnt_after", 64'(bus.tok_cnt), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
